// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 access codes,
// fault-cause encoding, LSU state encoding and the access-size decode.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_BUS_ERR  = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } fault_cause_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } access_size_e;

    // The low funct3 bits select the size; the otherwise unused code 11 behaves as a word.
    function automatic access_size_e decode_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   decode_size = SIZE_B;
            2'b01:   decode_size = SIZE_H;
            default: decode_size = SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte enables and replicated
// write data on the request side, load extraction and extension on the response side.
module lsu_align
    import rv32i_pkg::*;
(
    input  access_size_e req_size_i,
    input  logic [1:0]   req_offset_i,
    input  logic [31:0]  req_wdata_i,
    input  access_size_e rsp_size_i,
    input  logic         rsp_signed_i,
    input  logic [1:0]   rsp_offset_i,
    input  logic [31:0]  rsp_rdata_i,
    output logic [3:0]   be_o,
    output logic [31:0]  wdata_o,
    output logic         misaligned_o,
    output logic [31:0]  rdata_o
);

    logic [31:0] lane;

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = req_wdata_i;
        misaligned_o = 1'b0;
        case (req_size_i)
            SIZE_B: begin
                be_o    = 4'b0001 << req_offset_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            SIZE_H: begin
                be_o         = 4'b0011 << {req_offset_i[1], 1'b0};
                wdata_o      = {2{req_wdata_i[15:0]}};
                misaligned_o = req_offset_i[0];
            end
            default: begin
                be_o         = 4'b1111;
                misaligned_o = |req_offset_i;
            end
        endcase
    end

    // The addressed byte/halfword is shifted down to bit 0 before extension.
    always_comb begin
        lane    = rsp_rdata_i >> {rsp_offset_i, 3'b000};
        rdata_o = lane;
        case (rsp_size_i)
            SIZE_B:  rdata_o = {{24{rsp_signed_i & lane[7]}}, lane[7:0]};
            SIZE_H:  rdata_o = {{16{rsp_signed_i & lane[15]}}, lane[15:0]};
            default: rdata_o = lane;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// Memory-stage load/store unit: one req/gnt/rvalid bus transaction per
// EX/MEM memory op, stalling the pipeline until it completes or faults.
module data_lsu
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] ReadData_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic TIMEOUT_EN = (TIMEOUT != 0);

    lsu_state_e   state_q, state_d;
    fault_cause_e cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         is_load_q, is_load_d;
    access_size_e size_q, size_d;
    logic         signed_q, signed_d;
    logic [1:0]   offset_q, offset_d;
    logic [29:0]  addr_q, addr_d;
    logic         we_q, we_d;
    logic [3:0]   be_q, be_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  rdata_q, rdata_d;

    logic         op;
    logic         timeout_hit;
    logic [3:0]   align_be;
    logic [31:0]  align_wdata;
    logic         align_misaligned;
    logic [31:0]  align_rdata;

    lsu_align u_align (
        .req_size_i   (decode_size(funct3_i[1:0])),
        .req_offset_i (addr_i[1:0]),
        .req_wdata_i  (wdata_i),
        .rsp_size_i   (size_q),
        .rsp_signed_i (signed_q),
        .rsp_offset_i (offset_q),
        .rsp_rdata_i  (data_rdata_i),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .misaligned_o (align_misaligned),
        .rdata_o      (align_rdata)
    );

    assign op          = MemRead_i | MemWrite_i;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        size_d    = size_q;
        signed_d  = signed_q;
        offset_d  = offset_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        stall_o   = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                stall_o = op;
                if (op) begin
                    is_load_d = ~MemWrite_i;
                    size_d    = decode_size(funct3_i[1:0]);
                    signed_d  = ~funct3_i[2];
                    offset_d  = addr_i[1:0];
                    if (align_misaligned) begin
                        state_d = LSU_DONE;
                        cause_d = CAUSE_MISALIGN;
                        if (!MemWrite_i) begin
                            rdata_d = '0;
                        end
                    end else begin
                        state_d = LSU_REQ;
                        cnt_d   = '0;
                        addr_d  = addr_i[31:2];
                        we_d    = MemWrite_i;
                        be_d    = align_be;
                        wdata_d = align_wdata;
                    end
                end
            end
            // The timeout takes precedence over a grant arriving in the same cycle.
            LSU_REQ: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (timeout_hit) begin
                    state_d = LSU_DONE;
                    cause_d = CAUSE_TIMEOUT;
                    if (is_load_q) begin
                        rdata_d = '0;
                    end
                end else if (data_gnt_i) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (data_rvalid_i) begin
                    state_d = LSU_DONE;
                    if (data_err_i) begin
                        cause_d = CAUSE_BUS_ERR;
                        if (is_load_q) begin
                            rdata_d = '0;
                        end
                    end else if (is_load_q) begin
                        rdata_d = align_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d = LSU_DONE;
                    cause_d = CAUSE_TIMEOUT;
                    if (is_load_q) begin
                        rdata_d = '0;
                    end
                end
            end
            default: begin
                state_d = LSU_IDLE;
                cause_d = CAUSE_NONE;
                cnt_d   = '0;
            end
        endcase

        // Bus outputs return to idle values as soon as the access is finished.
        if (state_d == LSU_DONE) begin
            addr_d  = '0;
            we_d    = 1'b0;
            be_d    = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= LSU_IDLE;
            cause_q   <= CAUSE_NONE;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            size_q    <= SIZE_B;
            signed_q  <= 1'b0;
            offset_q  <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            offset_q  <= offset_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_req_o    = (state_q == LSU_REQ);
    assign data_we_o     = we_q;
    assign data_be_o     = be_q;
    assign data_addr_o   = {addr_q, 2'b00};
    assign data_wdata_o  = wdata_q;
    assign ReadData_o    = rdata_q;
    assign fault_cause_o = cause_q;
    assign fault_o       = (cause_q != CAUSE_NONE);

endmodule

// File: tb/tb_data_lsu.sv
// Directed bench for data_lsu: aligned loads/stores, misalignment, bus error,
// timeout (on a second instance with a short limit) and asynchronous reset.
module tb_data_lsu;
    import rv32i_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        mem_read, mem_write, to_read, to_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    logic        stall, fault, req, we;
    logic [31:0] read_data, bus_addr, bus_wdata;
    logic [1:0]  cause;
    logic [3:0]  be;

    logic        to_stall, to_fault, to_req, to_we;
    logic [31:0] to_read_data, to_bus_addr, to_bus_wdata;
    logic [1:0]  to_cause;
    logic [3:0]  to_be;

    int vectors = 0;
    int miscompares = 0;

    data_lsu dut (
        .CLK(CLK), .nRST(nRST), .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall), .ReadData_o(read_data), .fault_o(fault), .fault_cause_o(cause),
        .data_req_o(req), .data_we_o(we), .data_be_o(be), .data_addr_o(bus_addr),
        .data_wdata_o(bus_wdata), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
        .data_rdata_i(rdata), .data_err_i(err)
    );

    data_lsu #(.TIMEOUT(4)) dut_to (
        .CLK(CLK), .nRST(nRST), .MemRead_i(to_read), .MemWrite_i(to_write),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .stall_o(to_stall), .ReadData_o(to_read_data), .fault_o(to_fault),
        .fault_cause_o(to_cause), .data_req_o(to_req), .data_we_o(to_we), .data_be_o(to_be),
        .data_addr_o(to_bus_addr), .data_wdata_o(to_bus_wdata), .data_gnt_i(gnt),
        .data_rvalid_i(rvalid), .data_rdata_i(rdata), .data_err_i(err)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, ".req"},   req,       0);
        check_output({tag, ".we"},    we,        0);
        check_output({tag, ".be"},    be,        0);
        check_output({tag, ".addr"},  bus_addr,  0);
        check_output({tag, ".wdata"}, bus_wdata, 0);
        check_output({tag, ".stall"}, stall,     0);
        check_output({tag, ".fault"}, fault,     0);
        check_output({tag, ".cause"}, cause,     0);
    endtask

    task automatic check_to_idle(input string tag);
        check_output({tag, ".to_req"},   to_req,       0);
        check_output({tag, ".to_we"},    to_we,        0);
        check_output({tag, ".to_be"},    to_be,        0);
        check_output({tag, ".to_addr"},  to_bus_addr,  0);
        check_output({tag, ".to_wdata"}, to_bus_wdata, 0);
        check_output({tag, ".to_stall"}, to_stall,     0);
        check_output({tag, ".to_fault"}, to_fault,     0);
        check_output({tag, ".to_cause"}, to_cause,     0);
    endtask

    // Zero-wait load: op in cycle 0, REQ+gnt in 1, WAIT+rvalid in 2, DONE in 3.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp_rd);
        tick();
        apply_stimulus(1'b1, 1'b0, f3, a, 32'h0);
        #1;
        check_output({tag, ".c0_stall"}, stall, 1);
        check_output({tag, ".c0_req"},   req,   0);
        tick();
        gnt = 1'b1;
        #1;
        check_output({tag, ".c1_req"},  req,      1);
        check_output({tag, ".c1_addr"}, bus_addr, {a[31:2], 2'b00});
        check_output({tag, ".c1_we"},   we,       0);
        if (f3 == F3_W) check_output({tag, ".c1_be"}, be, 4'b1111);
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = rd;
        #1;
        check_output({tag, ".c2_req"},   req,   0);
        check_output({tag, ".c2_stall"}, stall, 1);
        tick();
        rvalid   = 1'b0;
        rdata    = 32'h0;
        mem_read = 1'b0;
        #1;
        check_output({tag, ".c3_stall"}, stall,     0);
        check_output({tag, ".c3_fault"}, fault,     0);
        check_output({tag, ".c3_rdata"}, read_data, exp_rd);
        tick();
        #1;
        check_idle({tag, ".c4"});
        check_output({tag, ".c4_rdata_hold"}, read_data, exp_rd);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] held_rd);
        tick();
        apply_stimulus(1'b0, 1'b1, f3, a, wd);
        #1;
        check_output({tag, ".c0_stall"}, stall, 1);
        tick();
        gnt = 1'b1;
        #1;
        check_output({tag, ".c1_req"},   req,       1);
        check_output({tag, ".c1_we"},    we,        1);
        check_output({tag, ".c1_addr"},  bus_addr,  exp_addr);
        check_output({tag, ".c1_be"},    be,        exp_be);
        check_output({tag, ".c1_wdata"}, bus_wdata, exp_wd);
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        #1;
        check_output({tag, ".c2_stall"}, stall, 1);
        tick();
        rvalid    = 1'b0;
        mem_write = 1'b0;
        #1;
        check_output({tag, ".c3_stall"}, stall,     0);
        check_output({tag, ".c3_fault"}, fault,     0);
        check_output({tag, ".c3_rdata"}, read_data, held_rd);
        tick();
        #1;
        check_idle({tag, ".c4"});
    endtask

    initial begin
        nRST = 1'b0;
        apply_stimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        to_read = 1'b0; to_write = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = 32'h0;
        #3;
        check_idle("reset");
        check_output("reset.rdata", read_data, 0);
        check_to_idle("reset");
        tick();
        tick();
        nRST = 1'b1;
        tick();
        #1;
        check_idle("nonmem");

        do_load("lw100",  F3_W,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb103",  F3_B,  32'h103, 32'h80112233, 32'hFFFFFF80);
        do_load("lbu103", F3_BU, 32'h103, 32'h80112233, 32'h00000080);
        do_load("lb101",  F3_B,  32'h101, 32'h80112233, 32'h00000022);
        do_load("lh102",  F3_H,  32'h102, 32'h80112233, 32'hFFFF8011);
        do_load("lhu102", F3_HU, 32'h102, 32'h80112233, 32'h00008011);

        do_store("sh206", F3_H, 32'h206, 32'h1234ABCD, 32'h204, 4'b1100, 32'hABCDABCD, 32'h00008011);
        do_store("sb301", F3_B, 32'h301, 32'h1234565A, 32'h300, 4'b0010, 32'h5A5A5A5A, 32'h00008011);
        do_store("sw40c", F3_W, 32'h40C, 32'hCAFEF00D, 32'h40C, 4'b1111, 32'hCAFEF00D, 32'h00008011);

        // Misaligned store leaves ReadData alone; misaligned load forces it to zero.
        tick();
        apply_stimulus(1'b0, 1'b1, F3_H, 32'h203, 32'h55);
        #1;
        check_output("missh.c0_stall", stall, 1);
        tick();
        mem_write = 1'b0;
        #1;
        check_output("missh.c1_req",   req,       0);
        check_output("missh.c1_fault", fault,     1);
        check_output("missh.c1_cause", cause,     2'b01);
        check_output("missh.c1_stall", stall,     0);
        check_output("missh.c1_rdata", read_data, 32'h00008011);
        tick();
        #1;
        check_idle("missh.c2");

        tick();
        apply_stimulus(1'b1, 1'b0, F3_W, 32'h101, 32'h0);
        #1;
        check_output("mislw.c0_stall", stall, 1);
        tick();
        mem_read = 1'b0;
        #1;
        check_output("mislw.c1_req",   req,       0);
        check_output("mislw.c1_fault", fault,     1);
        check_output("mislw.c1_cause", cause,     2'b01);
        check_output("mislw.c1_stall", stall,     0);
        check_output("mislw.c1_rdata", read_data, 0);
        tick();
        #1;
        check_idle("mislw.c2");

        // Grant withheld three cycles, one rvalid-wait cycle, then an error response.
        do_load("lw_pre", F3_W, 32'h104, 32'h13572468, 32'h13572468);
        tick();
        apply_stimulus(1'b1, 1'b0, F3_W, 32'h500, 32'h0);
        #1;
        check_output("berr.c0_stall", stall, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1;
            check_output("berr.nognt_req",  req,      1);
            check_output("berr.nognt_addr", bus_addr, 32'h500);
        end
        tick();
        gnt = 1'b1;
        #1;
        check_output("berr.c4_req", req, 1);
        tick();
        gnt = 1'b0;
        #1;
        check_output("berr.c5_req",   req,   0);
        check_output("berr.c5_stall", stall, 1);
        tick();
        rvalid = 1'b1; err = 1'b1; rdata = 32'h12345678;
        #1;
        check_output("berr.c6_stall", stall, 1);
        tick();
        rvalid = 1'b0; err = 1'b0; rdata = 32'h0; mem_read = 1'b0;
        #1;
        check_output("berr.c7_fault", fault,     1);
        check_output("berr.c7_cause", cause,     2'b10);
        check_output("berr.c7_stall", stall,     0);
        check_output("berr.c7_rdata", read_data, 0);
        tick();
        #1;
        check_idle("berr.c8");

        // Short-timeout instance: four REQ cycles without a grant, then a late rvalid.
        tick();
        funct3 = F3_W; addr = 32'h600; to_read = 1'b1;
        #1;
        check_output("tmo.c0_stall", to_stall, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            #1;
            check_output("tmo.req",   to_req,   1);
            check_output("tmo.stall", to_stall, 1);
        end
        tick();
        to_read = 1'b0; rvalid = 1'b1; rdata = 32'hFFFFFFFF;
        #1;
        check_output("tmo.c5_req",   to_req,       0);
        check_output("tmo.c5_fault", to_fault,     1);
        check_output("tmo.c5_cause", to_cause,     2'b11);
        check_output("tmo.c5_stall", to_stall,     0);
        check_output("tmo.c5_rdata", to_read_data, 0);
        tick();
        #1;
        check_to_idle("tmo.c6");
        check_output("tmo.c6_rdata", to_read_data, 0);
        rvalid = 1'b0; rdata = 32'h0;
        check_idle("tmo.main");

        // Asynchronous reset in WAIT abandons the access immediately.
        do_load("lw_pre2", F3_W, 32'h108, 32'h0BADF00D, 32'h0BADF00D);
        tick();
        apply_stimulus(1'b1, 1'b0, F3_W, 32'h700, 32'h0);
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #1;
        check_output("rst.wait_stall", stall, 1);
        check_output("rst.wait_req",   req,   0);
        mem_read = 1'b0;
        nRST = 1'b0;
        #1;
        check_idle("rst.async");
        check_output("rst.async_rdata", read_data, 0);
        tick();
        nRST = 1'b1;
        rvalid = 1'b1; rdata = 32'hA5A5A5A5;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        #1;
        check_idle("rst.after");
        check_output("rst.after_rdata", read_data, 0);
        check_to_idle("rst.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
